img2col_stream: RTL and testbench

//  Streaming image-to-column mapper for the CNN datapath; parametrised successor of the fixed 28-row, 5x5 mapper.

---
 rtl/img2col_stream_pkg.sv | 16 +
 rtl/img2col_stream_line_buffer.sv | 44 ++++
 rtl/img2col_stream.sv | 162 ++++++++++++++++
 tb/tb_img2col_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img2col_stream_pkg.sv
// Shared types and helpers for the streaming image-to-column mapper.
package img2col_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} map_state_t;

   function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                           input int unsigned s);
      return (img - k) / s + 1;
   endfunction

   function automatic bit cfg_ok(input int unsigned img_w, input int unsigned img_h,
                                 input int unsigned k, input int unsigned s);
      return (k >= 2) && (s >= 1) && (s <= k) && (img_w >= k) && (img_h >= k);
   endfunction

endpackage

// File: rtl/img2col_stream_line_buffer.sv
// K-1 circular row buffers: one write and ROWS parallel reads per cycle at a shared column.
module line_buffer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 28,
   parameter int unsigned ROWS   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic                           row_adv,
   input  logic [$clog2(DEPTH)-1:0]       addr,
   input  logic [DATA_W-1:0]              wr_data,
   output logic [ROWS-1:0][DATA_W-1:0]    rd_data
);

   localparam int unsigned PW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [DATA_W-1:0] mem [ROWS][DEPTH];
   logic [PW-1:0]     ptr;

   // ptr names the slot holding the oldest row; that row is overwritten by the current one
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (row_adv)
         ptr <= (ptr == PW'(ROWS - 1)) ? '0 : ptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[ptr][addr] <= wr_data;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_rd
      logic [PW:0] sum;
      logic [PW:0] slot;
      always_comb begin
         sum  = {1'b0, ptr} + (PW + 1)'(r);
         slot = (sum >= (PW + 1)'(ROWS)) ? sum - (PW + 1)'(ROWS) : sum;
         rd_data[r] = mem[slot[PW-1:0]][addr];
      end
   end

endmodule

// File: rtl/img2col_stream.sv
// Streaming image-to-column mapper: row-major pixels in, every strided KxK window out as a flat vector.
module img2col_stream
   import img2col_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned K      = 5,
   parameter int unsigned S      = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [K*K-1:0][DATA_W-1:0]    out_win,
   output logic [$clog2(out_dim(IMG_W, K, S) * out_dim(IMG_H, K, S))-1:0] col_num,
   output logic                          map_finish
);

   localparam int unsigned OUT_W  = out_dim(IMG_W, K, S);
   localparam int unsigned OUT_H  = out_dim(IMG_H, K, S);
   localparam int unsigned NWIN   = OUT_W * OUT_H;
   localparam int unsigned CW     = $clog2(NWIN);
   localparam int unsigned XW     = $clog2(IMG_W);
   localparam int unsigned YW     = $clog2(IMG_H);
   localparam int unsigned SW     = (S > 1) ? $clog2(S) : 1;
   localparam bit          CFG_OK = cfg_ok(IMG_W, IMG_H, K, S);

   if (!CFG_OK) begin : g_cfg_check
      $error("img2col_stream: need K>=2, 1<=S<=K, IMG_W>=K, IMG_H>=K");
   end

   map_state_t state, state_next;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [SW-1:0] px, py;
   logic          pix_done;
   logic          accept, fire, last_x, last_y, emit, last_win;

   logic [K-1:0][K-1:0][DATA_W-1:0] win, win_next;
   logic [K-2:0][DATA_W-1:0]        lb_rd;

   assign accept   = in_valid && in_ready;
   assign fire     = out_valid && out_ready;
   assign last_x   = (x == XW'(IMG_W - 1));
   assign last_y   = (y == YW'(IMG_H - 1));
   assign last_win = (col_num == CW'(NWIN - 1));
   assign emit     = (y >= YW'(K - 1)) && (x >= XW'(K - 1)) && (px == '0) && (py == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      map_finish = 1'b0;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            in_ready = !pix_done && (!out_valid || out_ready);
            if (fire && last_win) state_next = DONE;
         end
         DONE: begin
            map_finish = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // px/py hold (x-K+1)%S and (y-K+1)%S once the window origin is in range, 0 before that
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x        <= '0;
         y        <= '0;
         px       <= '0;
         py       <= '0;
         pix_done <= 1'b0;
      end else if (state == IDLE && start) begin
         x        <= '0;
         y        <= '0;
         px       <= '0;
         py       <= '0;
         pix_done <= 1'b0;
      end else if (accept) begin
         if (last_x) begin
            x  <= '0;
            px <= '0;
            if (last_y) begin
               y        <= '0;
               py       <= '0;
               pix_done <= 1'b1;
            end else begin
               y <= y + 1'b1;
               if (y >= YW'(K - 1))
                  py <= (py == SW'(S - 1)) ? '0 : py + 1'b1;
            end
         end else begin
            x <= x + 1'b1;
            if (x >= XW'(K - 1))
               px <= (px == SW'(S - 1)) ? '0 : px + 1'b1;
         end
      end
   end

   line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ROWS   (K - 1)
   ) u_line_buffer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .row_adv (accept && last_x),
      .addr    (x),
      .wr_data (in_data),
      .rd_data (lb_rd)
   );

   always_comb begin
      win_next = win;
      for (int unsigned r = 0; r < K; r++)
         for (int unsigned c = 0; c < K - 1; c++)
            win_next[r][c] = win[r][c+1];
      for (int unsigned r = 0; r < K - 1; r++)
         win_next[r][K-1] = lb_rd[r];
      win_next[K-1][K-1] = in_data;
   end

   always_ff @(posedge clk) begin
      if (accept)
         win <= win_next;
   end

   // win_next[r][c] sits at flat index r*K+c, so the packed copy lands in out_win order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_win   <= '0;
         col_num   <= '0;
      end else begin
         if (fire)
            col_num <= last_win ? '0 : col_num + 1'b1;
         if (accept && emit) begin
            out_valid <= 1'b1;
            out_win   <= win_next;
         end else if (fire) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_img2col_stream.sv
// Scoreboard bench for img2col_stream: default 28x28/K5/S1 instance plus an 8x8/K3/S2 instance.
module tb_img2col_stream;

   localparam int DW   = 16;
   localparam int IMGA = 28;
   localparam int KA   = 5;
   localparam int SA   = 1;
   localparam int OWA  = (IMGA - KA) / SA + 1;
   localparam int NWA  = OWA * OWA;
   localparam int IMGB = 8;
   localparam int KB   = 3;
   localparam int SB   = 2;
   localparam int OWB  = (IMGB - KB) / SB + 1;
   localparam int NWB  = OWB * OWB;
   localparam int WA   = KA * KA * DW;

   typedef struct {
      int unsigned     idx;
      logic [WA-1:0]   win;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_a, in_valid_a, in_ready_a, out_valid_a, map_finish_a;
   logic out_ready_a = 1'b1;
   logic [DW-1:0] in_data_a;
   logic [KA*KA-1:0][DW-1:0] out_win_a;
   logic [$clog2(NWA)-1:0] col_num_a;

   logic start_b, in_valid_b, in_ready_b, out_valid_b, map_finish_b;
   logic out_ready_b = 1'b1;
   logic [DW-1:0] in_data_b;
   logic [KB*KB-1:0][DW-1:0] out_win_b;
   logic [$clog2(NWB)-1:0] col_num_b;

   img2col_stream #(.DATA_W(DW), .IMG_W(IMGA), .IMG_H(IMGA), .K(KA), .S(SA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_data(in_data_a),
      .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_win(out_win_a), .col_num(col_num_a), .map_finish(map_finish_a));

   img2col_stream #(.DATA_W(DW), .IMG_W(IMGB), .IMG_H(IMGB), .K(KB), .S(SB)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
      .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_win(out_win_b), .col_num(col_num_b), .map_finish(map_finish_b));

   int n_cmp = 0;
   int n_bad = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int unsigned img_a [IMGA][IMGA];
   int unsigned img_b [IMGB][IMGB];
   int  win_cnt_a, win_cnt_b, stall_cnt;
   bit  pat_a, fin_due_a, bp_done;
   int  rdy_mode = 0;
   int  bp_cnt = 0;

   task automatic check_val(input string tag, input logic [WA-1:0] got, input logic [WA-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void push_a(input int y, input int x);
      exp_t e;
      if (y >= KA-1 && x >= KA-1 && (y-KA+1) % SA == 0 && (x-KA+1) % SA == 0) begin
         e.idx = ((y-KA+1) / SA) * OWA + (x-KA+1) / SA;
         e.win = '0;
         for (int r = 0; r < KA; r++)
            for (int c = 0; c < KA; c++)
               e.win[(r*KA+c)*DW +: DW] = DW'(img_a[y-KA+1+r][x-KA+1+c]);
         q_a.push_back(e);
      end
   endfunction

   function automatic void push_b(input int y, input int x);
      exp_t e;
      if (y >= KB-1 && x >= KB-1 && (y-KB+1) % SB == 0 && (x-KB+1) % SB == 0) begin
         e.idx = ((y-KB+1) / SB) * OWB + (x-KB+1) / SB;
         e.win = '0;
         for (int r = 0; r < KB; r++)
            for (int c = 0; c < KB; c++)
               e.win[(r*KB+c)*DW +: DW] = DW'(img_b[y-KB+1+r][x-KB+1+c]);
         q_b.push_back(e);
      end
   endfunction

   // out_ready policy: 0 always ready, 1 random, 2 ten-cycle stall when window 3 appears
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1: out_ready_a = ($urandom_range(0, 3) != 0);
         2: begin
            if (bp_cnt > 0) begin
               out_ready_a = 1'b0;
               bp_cnt--;
            end else if (!bp_done && out_valid_a && col_num_a == 3) begin
               out_ready_a = 1'b0;
               bp_cnt = 9;
               bp_done = 1'b1;
            end else begin
               out_ready_a = 1'b1;
            end
         end
         default: out_ready_a = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      exp_t e;
      check_val("map_finish", map_finish_a, fin_due_a);
      fin_due_a = 1'b0;
      if (rdy_mode == 2 && out_valid_a && !out_ready_a) begin
         stall_cnt++;
         check_val("bp_in_ready", in_ready_a, 0);
         check_val("bp_col_num", col_num_a, 3);
         if (q_a.size() > 0) check_val("bp_win", out_win_a, q_a[0].win);
      end
      if (out_valid_a && out_ready_a) begin
         check_val("sb_a_nonempty", q_a.size() > 0, 1);
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check_val("col_num_a", col_num_a, e.idx);
            check_val("win_a", out_win_a, e.win);
         end
         if (pat_a && col_num_a == 0) begin
            check_val("first_w0", out_win_a[0], 0);
            check_val("first_w24", out_win_a[24], 116);
         end
         if (pat_a && col_num_a == NWA-1) check_val("last_w0", out_win_a[0], 667);
         if (col_num_a == NWA-1) fin_due_a = 1'b1;
         win_cnt_a++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (out_valid_b && out_ready_b) begin
         check_val("sb_b_nonempty", q_b.size() > 0, 1);
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check_val("col_num_b", col_num_b, e.idx);
            check_val("win_b", out_win_b, e.win);
         end
         if (col_num_b == 4) begin
            check_val("b4_w0", out_win_b[0], 18);
            check_val("b4_w8", out_win_b[8], 36);
         end
         win_cnt_b++;
      end
   end

   task automatic run_frame_a(input bit rnd, input bit gaps, input bit spurious, input int abort_at);
      int  n = 0;
      bit  ok;
      bit  fin = 1'b0;
      win_cnt_a = 0;
      pat_a = !rnd;
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int y = 0; y < IMGA; y++) begin
         for (int x = 0; x < IMGA; x++) begin
            if (abort_at > 0 && n == abort_at) return;
            img_a[y][x] = rnd ? $urandom_range(0, 65535) : y * IMGA + x;
            if (gaps) begin
               in_valid_a = 1'b0;
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            start_a    = spurious && (n == 50 || n == 300);
            in_valid_a = 1'b1;
            in_data_a  = DW'(img_a[y][x]);
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
               @(negedge clk);
               if (in_ready_a) begin
                  ok = 1'b1;
                  push_a(y, x);
               end
               @(posedge clk); #1;
            end
            start_a    = 1'b0;
            in_valid_a = 1'b0;
            if (!ok) begin
               check_val("pix_accept_timeout", 0, 1);
               return;
            end
            n++;
         end
      end
      for (int t = 0; t < 300 && !fin; t++) begin
         @(negedge clk);
         fin = map_finish_a;
      end
      check_val("frame_finish", fin, 1);
      check_val("win_count_a", win_cnt_a, NWA);
      check_val("sb_a_drained", q_a.size(), 0);
   endtask

   task automatic run_b();
      bit ok;
      bit fin = 1'b0;
      win_cnt_b = 0;
      @(posedge clk); #1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int y = 0; y < IMGB && !fin; y++) begin
         for (int x = 0; x < IMGB && !fin; x++) begin
            img_b[y][x] = y * IMGB + x;
            in_valid_b  = 1'b1;
            in_data_b   = DW'(img_b[y][x]);
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok && !fin; t++) begin
               @(negedge clk);
               if (map_finish_b) fin = 1'b1;
               else if (in_ready_b) begin
                  ok = 1'b1;
                  push_b(y, x);
               end
               @(posedge clk); #1;
            end
            in_valid_b = 1'b0;
            if (!ok && !fin) check_val("b_pix_timeout", 0, 1);
         end
      end
      for (int t = 0; t < 50 && !fin; t++) begin
         @(negedge clk);
         fin = map_finish_b;
      end
      check_val("b_finish", fin, 1);
      check_val("win_count_b", win_cnt_b, NWB);
      check_val("sb_b_drained", q_b.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_out_valid"}, out_valid_a, 0);
      check_val({tag, "_in_ready"}, in_ready_a, 0);
      check_val({tag, "_map_finish"}, map_finish_a, 0);
      check_val({tag, "_col_num"}, col_num_a, 0);
      check_val({tag, "_out_win"}, out_win_a, 0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
      start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_idle_outputs("reset");
      check_val("reset_b_out_valid", out_valid_b, 0);
      check_val("reset_b_col_num", col_num_b, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_frame_a(1'b0, 1'b0, 1'b0, 0);

      run_b();

      rdy_mode = 2; bp_done = 1'b0; stall_cnt = 0;
      run_frame_a(1'b0, 1'b0, 1'b0, 0);
      check_val("bp_stall_cycles", stall_cnt, 10);
      rdy_mode = 0;

      run_frame_a(1'b0, 1'b0, 1'b0, 100);
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      q_a.delete();
      run_frame_a(1'b0, 1'b0, 1'b0, 0);

      in_valid_a = 1'b1;
      in_data_a  = 16'hdead;
      repeat (5) begin
         @(negedge clk);
         check_val("idle_in_ready", in_ready_a, 0);
      end
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      run_frame_a(1'b0, 1'b0, 1'b1, 0);

      rdy_mode = 1;
      run_frame_a(1'b1, 1'b1, 1'b0, 0);
      run_frame_a(1'b1, 1'b1, 1'b0, 0);
      rdy_mode = 0;

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
